// File: rtl/kl_req_arbiter_if.sv
// Bus bundle for the KLink request arbiter: N upstream master ports on one
// side and a single downstream KLink request/response port on the other.
interface kl_req_arbiter_if #(
  parameter int N = 4
);
  // Upstream masters, packed with master i in slice i
  logic [N*32-1:0] m_req_addr;
  logic [N-1:0]    m_req_wen;
  logic [N*64-1:0] m_req_wdata;
  logic [N*8-1:0]  m_req_wmask;
  logic [N*3-1:0]  m_req_size;
  logic [N-1:0]    m_req_valid;
  logic [N-1:0]    m_req_ready;
  logic [63:0]     m_resp_rdata;
  logic            m_resp_ren;
  logic [2:0]      m_resp_size;
  logic [N-1:0]    m_resp_valid;
  logic [N-1:0]    m_resp_ready;

  // Shared downstream KLink port
  logic [31:0]     kl_req_addr;
  logic            kl_req_wen;
  logic [63:0]     kl_req_wdata;
  logic [7:0]      kl_req_wmask;
  logic [2:0]      kl_req_size;
  logic [4:0]      kl_req_srcid;
  logic            kl_req_valid;
  logic            kl_req_ready;
  logic [63:0]     kl_resp_rdata;
  logic            kl_resp_ren;
  logic [2:0]      kl_resp_size;
  logic [4:0]      kl_resp_dstid;
  logic            kl_resp_valid;
  logic            kl_resp_ready;

  // The arbiter itself: serves the upstream masters and drives the
  // downstream request port.
  modport slave (
    input  m_req_addr, m_req_wen, m_req_wdata, m_req_wmask, m_req_size,
    input  m_req_valid,
    output m_req_ready,
    output m_resp_rdata, m_resp_ren, m_resp_size, m_resp_valid,
    input  m_resp_ready,
    output kl_req_addr, kl_req_wen, kl_req_wdata, kl_req_wmask, kl_req_size,
    output kl_req_srcid, kl_req_valid,
    input  kl_req_ready,
    input  kl_resp_rdata, kl_resp_ren, kl_resp_size, kl_resp_dstid, kl_resp_valid,
    output kl_resp_ready
  );

  // The surroundings: upstream masters plus the downstream KLink target.
  modport master (
    output m_req_addr, m_req_wen, m_req_wdata, m_req_wmask, m_req_size,
    output m_req_valid,
    input  m_req_ready,
    input  m_resp_rdata, m_resp_ren, m_resp_size, m_resp_valid,
    output m_resp_ready,
    input  kl_req_addr, kl_req_wen, kl_req_wdata, kl_req_wmask, kl_req_size,
    input  kl_req_srcid, kl_req_valid,
    output kl_req_ready,
    output kl_resp_rdata, kl_resp_ren, kl_resp_size, kl_resp_dstid, kl_resp_valid,
    input  kl_resp_ready
  );
endinterface

// File: rtl/kl_req_arbiter.sv
// KLink request arbiter: shares one downstream KLink port among N masters.
// Requests are picked round-robin, tagged with a source ID and pushed through
// one output register. Responses are steered back by their destination ID.
// A per-master outstanding counter keeps a master from flooding the response
// side; a master at its limit simply drops out of arbitration.
module kl_req_arbiter #(
  parameter int         N          = 4,
  parameter logic [4:0] SRCID_BASE = 5'd0,
  parameter int         MAX_OUT    = 4
) (
  input  logic             clk,
  input  logic             rst,
  kl_req_arbiter_if.slave  bus,
  output logic             err_dstid
);

  localparam int IW = $clog2(N);
  localparam int CW = 4;

  logic [N-1:0]    eligible;
  logic [IW-1:0]   rr_ptr;
  logic            grant_valid;
  logic [IW-1:0]   grant_idx;
  logic            load_en;
  logic [N-1:0]    req_ready;
  logic            req_accept;
  logic [CW-1:0]   out_cnt [N];
  logic [N-1:0]    cnt_inc;
  logic [N-1:0]    cnt_dec;

  logic [4:0]      resp_idx;
  logic            resp_mapped;
  logic [IW-1:0]   resp_sel;
  logic [N-1:0]    resp_valid;
  logic            resp_ready;
  logic            resp_hs;

  // Index arithmetic modulo N, used by both the search and the pointer update.
  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= N) sum = sum - N;
    return IW'(sum);
  endfunction

  // A master may compete only while it has room for another outstanding request.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < N; i++) begin
      eligible[i] = bus.m_req_valid[i] && (out_cnt[i] < CW'(MAX_OUT));
    end
  end

  // Round-robin search starting at rr_ptr; the first eligible master wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < N; k++) begin
      if (!grant_valid && eligible[wrap_add(rr_ptr, k)]) begin
        grant_valid = 1'b1;
        grant_idx   = wrap_add(rr_ptr, k);
      end
    end
  end

  assign load_en = !bus.kl_req_valid || bus.kl_req_ready;

  // Ready goes only to the winner and only when the output register can take
  // a new entry; held low while reset is asserted.
  always_comb begin
    req_ready = '0;
    if (rst && load_en && grant_valid) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  assign bus.m_req_ready = req_ready;
  assign req_accept      = |req_ready;

  // Output register: captures the winner's request and advances the pointer
  // past it; drains to invalid when downstream accepts and nobody is waiting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.kl_req_valid <= 1'b0;
      bus.kl_req_addr  <= '0;
      bus.kl_req_wen   <= 1'b0;
      bus.kl_req_wdata <= '0;
      bus.kl_req_wmask <= '0;
      bus.kl_req_size  <= '0;
      bus.kl_req_srcid <= '0;
      rr_ptr           <= '0;
    end else if (load_en) begin
      if (req_accept) begin
        bus.kl_req_valid <= 1'b1;
        bus.kl_req_addr  <= bus.m_req_addr[int'(grant_idx)*32 +: 32];
        bus.kl_req_wen   <= bus.m_req_wen[grant_idx];
        bus.kl_req_wdata <= bus.m_req_wdata[int'(grant_idx)*64 +: 64];
        bus.kl_req_wmask <= bus.m_req_wmask[int'(grant_idx)*8 +: 8];
        bus.kl_req_size  <= bus.m_req_size[int'(grant_idx)*3 +: 3];
        bus.kl_req_srcid <= SRCID_BASE + 5'(grant_idx);
        rr_ptr           <= wrap_add(grant_idx, 1);
      end else begin
        bus.kl_req_valid <= 1'b0;
      end
    end
  end

  // A destination ID below the base wraps to a value of at least 32-SRCID_BASE,
  // which is never below N, so the range compare also covers underflow.
  assign resp_idx    = bus.kl_resp_dstid - SRCID_BASE;
  assign resp_mapped = (bus.kl_resp_dstid >= SRCID_BASE) && (resp_idx < 5'(N));
  assign resp_sel    = resp_idx[IW-1:0];

  // Steer the response to its owner; unmapped responses are swallowed so the
  // downstream port never stalls on a bad tag.
  always_comb begin
    resp_valid = '0;
    resp_ready = 1'b1;
    if (resp_mapped) begin
      resp_valid[resp_sel] = bus.kl_resp_valid;
      resp_ready           = bus.m_resp_ready[resp_sel];
    end
  end

  assign bus.m_resp_valid  = resp_valid;
  assign bus.kl_resp_ready = resp_ready;
  assign bus.m_resp_rdata  = bus.kl_resp_rdata;
  assign bus.m_resp_ren    = bus.kl_resp_ren;
  assign bus.m_resp_size   = bus.kl_resp_size;
  assign resp_hs           = bus.kl_resp_valid && resp_ready;

  // Flag a dropped response for one cycle after its handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_dstid <= 1'b0;
    end else begin
      err_dstid <= resp_hs && !resp_mapped;
    end
  end

  // Per-master accept and retire events feeding the outstanding counters.
  always_comb begin
    cnt_inc = req_ready;
    cnt_dec = '0;
    if (resp_hs && resp_mapped) begin
      cnt_dec[resp_sel] = 1'b1;
    end
  end

  // Outstanding counters: accept and retire in the same cycle cancel, and a
  // stray response at zero leaves the counter at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        out_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (cnt_inc[i] && !cnt_dec[i]) begin
          out_cnt[i] <= out_cnt[i] + CW'(1);
        end else if (cnt_dec[i] && !cnt_inc[i] && (out_cnt[i] != '0)) begin
          out_cnt[i] <= out_cnt[i] - CW'(1);
        end
      end
    end
  end

endmodule

// File: doc/kl_req_arbiter.md
Name: kl_req_arbiter

Overview:
- Shares one KLink request/response port pair among N local KLink masters (CPU I-side, D-side, DMA, MLink bridge slave side).
- Request path: round-robin arbitration; each accepted request is tagged with a source ID; one registered output stage.
- Response path: routed back to the originating master by decoding the response destination ID.
- Per-master outstanding-transaction limit prevents response-side overflow.

Parameters:
- N, 4: number of upstream masters; legal range 2..8.
- SRCID_BASE, 5'd0: srcid = SRCID_BASE + master index; SRCID_BASE+N-1 must be ≤ 31.
- MAX_OUT, 4: maximum outstanding requests per master; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-low reset
- m_req_addr  in  N*32  per-master address, master i at bits [32i+31:32i]
- m_req_wen  in  N  write enable
- m_req_wdata  in  N*64  write data
- m_req_wmask  in  N*8  byte write mask
- m_req_size  in  N*3  log2 transfer size
- m_req_valid  in  N  request valid
- m_req_ready  out  N  request accepted
- m_resp_rdata  out  64  broadcast response data
- m_resp_ren  out  1  broadcast response carries read data
- m_resp_size  out  3  broadcast response size
- m_resp_valid  out  N  per-master response valid
- m_resp_ready  in  N  per-master response ready
- kl_req_addr / kl_req_wen / kl_req_wdata / kl_req_wmask / kl_req_size  out  32/1/64/8/3  downstream request
- kl_req_srcid  out  5  downstream request tag
- kl_req_valid  out  1  downstream request valid
- kl_req_ready  in  1  downstream request ready
- kl_resp_rdata / kl_resp_ren / kl_resp_size  in  64/1/3  downstream response
- kl_resp_dstid  in  5  response destination tag
- kl_resp_valid  in  1  downstream response valid
- kl_resp_ready  out  1  downstream response ready
- err_dstid  out  1  one-cycle pulse: response with unmapped dstid was dropped

Behaviour:
- Reset (rst low, asynchronous): kl_req_valid=0; all kl_req_* data=0; rr_ptr=0; all outstanding counters=0; err_dstid=0; m_req_ready=0.
- Eligible master i: m_req_valid[i]=1 and out_cnt[i] < MAX_OUT.
- Grant: combinational round-robin among eligible masters.
  - Search order: rr_ptr, rr_ptr+1, … mod N.
  - No eligible master → no grant.
- Output stage: single register; load_en = !kl_req_valid | kl_req_ready.
- m_req_ready[g] = 1 only for granted g, and only when load_en=1; all other bits 0. m_req_ready depends on m_req_valid but m_req_valid does not depend on m_req_ready.
- On m_req_valid[g] & m_req_ready[g]:
  - Output register loads master g's fields, srcid = SRCID_BASE+g; kl_req_valid=1 on the next cycle (1-cycle latency).
  - rr_ptr = (g+1) mod N.
  - out_cnt[g] increments.
- load_en=1 with no grant: kl_req_valid clears to 0.
- Back-to-back: with kl_req_ready held 1, sustains one request per cycle.
- kl_req_valid=1 with kl_req_ready=0: register contents hold stable.
- Response decode: idx = kl_resp_dstid - SRCID_BASE (5-bit).
  - idx < N: m_resp_valid[idx] = kl_resp_valid; kl_resp_ready = m_resp_ready[idx]. All other m_resp_valid bits = 0.
  - idx ≥ N, or subtraction underflows: kl_resp_ready=1; no m_resp_valid asserted; err_dstid pulses 1 the cycle after the handshake.
- Response data/ren/size are passed combinationally from the kl_resp_* inputs (0-cycle path).
- out_cnt[idx] decrements on a mapped response handshake.
- Same-cycle increment and decrement of one counter → counter unchanged.
- Decrement at 0 (spurious response) → counter saturates at 0.
- Counter at MAX_OUT → master ineligible until a response retires.
- Reset mid-transfer: in-flight request is discarded and counters clear; downstream must also be reset.

Test Plan:
- Single master, N=4: master 2 writes addr 0x1000, wmask 0xFF. Required: kl_req_valid one cycle later with srcid=2. Response with dstid=2 → only m_resp_valid[2] asserts.
- All four masters valid continuously, kl_req_ready=1. Required: grant order 0,1,2,3,0,… and srcid sequence 0,1,2,3,0 on consecutive cycles.
- kl_req_ready=0 for 5 cycles with masters pending. Required: output register contents stable; all m_req_ready=0; on release, grant resumes at rr_ptr.
- Master 1 issues 4 requests with no responses (MAX_OUT=4). Required: 5th request stalls and other masters are served. One dstid=1 response → master 1 granted again.
- Response with dstid=7 (N=4, SRCID_BASE=0). Required: kl_resp_ready=1, no m_resp_valid, err_dstid pulses once; counters unchanged.
- Assert rst low asynchronously while kl_req_valid=1 and counters nonzero. Required: kl_req_valid=0 immediately and all counters 0.
